// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between FIFO requesters and the write arbiter.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N    = 16,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   last;
  logic [NREQ*N-1:0] data;
  logic              full;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              wren;
  logic [N-1:0]      wdata;
  logic              busy;
  logic              ovf_err;

  modport slave (
    input  req, last, data, full,
    output gnt, ack, wren, wdata, busy, ovf_err
  );

  modport master (
    output req, last, data, full,
    input  gnt, ack, wren, wdata, busy, ovf_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for a FIFO write port: one owner holds the port
// until its last beat or until MAXBEAT beats, then priority moves past it.
module fifo_wr_arbiter #(
  parameter int unsigned N       = 16,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAXBEAT = 16
) (
  input  logic               wrclk,
  input  logic               wrrst,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MAXBEAT + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic            win_found;
  logic [IdxW-1:0] win_idx, cand;
  logic            own_req, own_last, beat_ok;
  logic [N-1:0]    own_data;
  logic [NREQ-1:0] ack;
  logic [N-1:0]    wdata;

  always_ff @(posedge wrclk or posedge wrrst) begin
    if (wrrst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_req  = bus.req[i];
        own_last = bus.last[i];
        own_data = bus.data[i*N +: N];
      end
    end
  end

  // First requester at or above ptr; IdxW-bit addition wraps modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + IdxW'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign beat_ok = (state_q == StBusy) && own_req && !bus.full;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d          = StBusy;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          cnt_d            = '0;
        end
      end
      StBusy: begin
        if (beat_ok) begin
          cnt_d = cnt_q + CntW'(1);
          if (own_last || (cnt_d == CntW'(MAXBEAT))) begin
            state_d = StIdle;
            gnt_d   = '0;
            ptr_d   = owner_q + IdxW'(1);
            ovf_d   = ovf_q | ~own_last;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack = '0;
    if (beat_ok) ack[owner_q] = 1'b1;
    wdata = (state_q == StBusy) ? own_data : '0;
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack;
  assign bus.wren    = beat_ok;
  assign bus.wdata   = wdata;
  assign bus.busy    = (state_q == StBusy);
  assign bus.ovf_err = ovf_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=16, NREQ=4, MAXBEAT=16).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_fifo_wr_arbiter;
  logic wrclk = 1'b0;
  logic wrrst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fifo_wr_arbiter_if #(.N(16), .NREQ(4)) bus ();

  fifo_wr_arbiter #(.N(16), .NREQ(4), .MAXBEAT(16)) dut (
    .wrclk (wrclk),
    .wrrst (wrrst),
    .bus   (bus)
  );

  always #5 wrclk = ~wrclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] gnt, input logic [3:0] ack,
                         input logic wren, input logic busy);
    chk({tag, ".gnt"},  64'(bus.gnt),  64'(gnt));
    chk({tag, ".ack"},  64'(bus.ack),  64'(ack));
    chk({tag, ".wren"}, 64'(bus.wren), 64'(wren));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(busy));
  endtask

  // Advance past the next rising edge, then let inputs settle before checks.
  task automatic cyc();
    @(posedge wrclk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [15:0] v);
    bus.data[i*16 +: 16] = v;
  endtask

  task automatic do_reset();
    wrrst    = 1'b1;
    bus.req  = '0;
    bus.last = '0;
    bus.full = 1'b0;
    bus.data = '0;
    cyc();
    cyc();
    chk_out("rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("rst.ovf", 64'(bus.ovf_err), 64'd0);
    wrrst = 1'b0;
  endtask

  initial begin
    bus.req  = '0;
    bus.last = '0;
    bus.full = 1'b0;
    bus.data = '0;

    // Round-robin between requesters 1 and 3, single-beat packets.
    do_reset();
    bus.req = 4'b1010; bus.last = 4'b1111;
    set_d(1, 16'h1111); set_d(3, 16'h3333);
    cyc(); #1 chk_out("rr.g1", 4'b0010, 4'b0010, 1'b1, 1'b1);
    chk("rr.wd1", 64'(bus.wdata), 64'h1111);
    cyc(); #1 chk_out("rr.i1", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(); #1 chk_out("rr.g3", 4'b1000, 4'b1000, 1'b1, 1'b1);
    chk("rr.wd3", 64'(bus.wdata), 64'h3333);
    cyc(); #1 chk_out("rr.i2", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(); #1 chk_out("rr.g1b", 4'b0010, 4'b0010, 1'b1, 1'b1);

    // Requester 0 three-beat packet while requester 2 waits.
    do_reset();
    bus.req = 4'b0101; bus.last = 4'b0000;
    set_d(0, 16'hA001); set_d(2, 16'hC000);
    cyc(); #1 chk_out("p3.b1", 4'b0001, 4'b0001, 1'b1, 1'b1);
    chk("p3.wd1", 64'(bus.wdata), 64'hA001);
    cyc(); set_d(0, 16'hA002);
    #1 chk_out("p3.b2", 4'b0001, 4'b0001, 1'b1, 1'b1);
    chk("p3.wd2", 64'(bus.wdata), 64'hA002);
    cyc(); set_d(0, 16'hA003); bus.last = 4'b0001;
    #1 chk_out("p3.b3", 4'b0001, 4'b0001, 1'b1, 1'b1);
    chk("p3.wd3", 64'(bus.wdata), 64'hA003);
    cyc(); bus.req = 4'b0100; bus.last = 4'b0000;
    #1 chk_out("p3.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(); #1 chk_out("p3.g2", 4'b0100, 4'b0100, 1'b1, 1'b1);
    chk("p3.wd2g", 64'(bus.wdata), 64'hC000);

    // FIFO full for four cycles in the middle of a packet.
    do_reset();
    bus.req = 4'b0010; bus.last = 4'b0000; set_d(1, 16'h1001);
    cyc(); #1 chk_out("fl.b1", 4'b0010, 4'b0010, 1'b1, 1'b1);
    cyc(); set_d(1, 16'h1002);
    #1 chk_out("fl.b2", 4'b0010, 4'b0010, 1'b1, 1'b1);
    cyc(); set_d(1, 16'h1003); bus.full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_out("fl.stall", 4'b0010, 4'b0000, 1'b0, 1'b1);
      cyc();
    end
    bus.full = 1'b0;
    #1 chk_out("fl.b3", 4'b0010, 4'b0010, 1'b1, 1'b1);
    chk("fl.wd3", 64'(bus.wdata), 64'h1003);
    cyc(); set_d(1, 16'h1004); bus.last = 4'b0010;
    #1 chk_out("fl.b4", 4'b0010, 4'b0010, 1'b1, 1'b1);
    chk("fl.wd4", 64'(bus.wdata), 64'h1004);
    cyc(); bus.req = 4'b0000;
    #1 chk_out("fl.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Forced release at MAXBEAT, then sticky ovf_err, then reset mid-packet.
    do_reset();
    bus.req = 4'b0010; bus.last = 4'b0000;
    cyc();
    for (int b = 1; b <= 16; b++) begin
      set_d(1, 16'(16'h2000 + b));
      #1 chk_out("mx.beat", 4'b0010, 4'b0010, 1'b1, 1'b1);
      chk("mx.ovf0", 64'(bus.ovf_err), 64'd0);
      cyc();
    end
    #1 chk_out("mx.rel", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("mx.ovf1", 64'(bus.ovf_err), 64'd1);
    bus.req = 4'b1111; bus.last = 4'b1111;
    cyc(); #1 chk_out("mx.g2", 4'b0100, 4'b0100, 1'b1, 1'b1);
    cyc(); #1 chk_out("mx.i2", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(); #1 chk_out("mx.g3", 4'b1000, 4'b1000, 1'b1, 1'b1);
    cyc(); bus.req = 4'b0010; bus.last = 4'b0010;
    #1 chk("mx.ovfs", 64'(bus.ovf_err), 64'd1);
    cyc(); #1 chk_out("mx.g1", 4'b0010, 4'b0010, 1'b1, 1'b1);
    cyc(); bus.req = 4'b0110; bus.last = 4'b0000;
    #1 chk_out("mx.i3", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(); #1 chk_out("rs.b1", 4'b0100, 4'b0100, 1'b1, 1'b1);
    chk("rs.ovf1", 64'(bus.ovf_err), 64'd1);
    cyc(); #1 chk_out("rs.b2", 4'b0100, 4'b0100, 1'b1, 1'b1);
    wrrst = 1'b1;
    #1 chk_out("rs.async", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("rs.ovf0", 64'(bus.ovf_err), 64'd0);
    cyc(); #1 chk_out("rs.hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
    wrrst = 1'b0;
    cyc(); #1 chk_out("rs.g1", 4'b0010, 4'b0010, 1'b1, 1'b1);

    // Owner drops req for two cycles while another requester waits.
    do_reset();
    bus.req = 4'b0011; bus.last = 4'b0000; set_d(0, 16'h0B01);
    cyc(); #1 chk_out("dr.b1", 4'b0001, 4'b0001, 1'b1, 1'b1);
    cyc(); bus.req = 4'b0010;
    #1 chk_out("dr.gap1", 4'b0001, 4'b0000, 1'b0, 1'b1);
    cyc(); #1 chk_out("dr.gap2", 4'b0001, 4'b0000, 1'b0, 1'b1);
    cyc(); bus.req = 4'b0011; bus.last = 4'b0001; set_d(0, 16'h0B02);
    #1 chk_out("dr.b2", 4'b0001, 4'b0001, 1'b1, 1'b1);
    chk("dr.wd2", 64'(bus.wdata), 64'h0B02);
    cyc(); bus.last = 4'b0000;
    #1 chk_out("dr.idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc(); #1 chk_out("dr.g1", 4'b0010, 4'b0010, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning write-data width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (power of two, 2..8).
REQ-003 The block SHALL have parameter MAXBEAT, default 16, meaning the maximum number of beats per packet before a forced release.
REQ-004 wrclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-005 wrrst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-requester write request, level-held while the requester has data.
REQ-007 last  input  NREQ  per-requester end-of-packet marker for the current beat.
REQ-008 data  input  NREQ*N  concatenated requester data; requester i occupies bits [i*N +: N].
REQ-009 full  input  1  FIFO full flag from the write pointer unit.
REQ-010 gnt  output  NREQ  registered one-hot grant; all zero when idle.
REQ-011 ack  output  NREQ  one-hot beat-accepted strobe to the owning requester.
REQ-012 wren  output  1  FIFO write enable.
REQ-013 wdata  output  N  FIFO write data, from the owning requester.
REQ-014 busy  output  1  high while a packet is owned (state BUSY).
REQ-015 ovf_err  output  1  sticky flag: a packet was force-released at MAXBEAT.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-017 In IDLE with any req bit high, the block SHALL select the winner by round-robin: first set req bit at or above priority pointer ptr, wrapping modulo NREQ.
REQ-018 On that edge the block SHALL register gnt to the winner's one-hot, store the owner index, clear the beat counter and enter BUSY; grant latency SHALL be 1 cycle from req.
REQ-019 In IDLE with req all zero, the block SHALL remain in IDLE with gnt zero.
REQ-020 In BUSY, wren SHALL equal req[owner] AND NOT full, combinationally.
REQ-021 In BUSY, wdata SHALL equal data[owner]; ack[owner] SHALL equal wren; all other ack bits SHALL be 0.
REQ-022 When full is high, wren and ack SHALL be 0 and the packet SHALL stay owned (no beat lost, no grant change).
REQ-023 When req[owner] deasserts mid-packet, the block SHALL hold BUSY and ownership until req returns.
REQ-024 On each accepted beat, the beat counter (ceil(log2(MAXBEAT+1)) bits) SHALL increment by 1.
REQ-025 On an accepted beat with last[owner] high, the block SHALL return to IDLE, clear gnt and set ptr to (owner+1) mod NREQ.
REQ-026 On an accepted beat without last that brings the beat counter to MAXBEAT, the block SHALL force-release exactly as in REQ-025 and set ovf_err.
REQ-027 Releasing on a packet's final beat SHALL leave one IDLE cycle before the next grant; maximum throughput is therefore one packet gap cycle.
REQ-028 Requests from non-owners SHALL be ignored during BUSY; req/last/data of non-owners SHALL have no effect.
REQ-029 ovf_err SHALL remain set until wrrst.

Reset
REQ-030 While wrrst is high, the block SHALL hold state IDLE, gnt=0, ptr=0, owner=0, beat counter=0, ovf_err=0, busy=0; wren and ack are consequently 0.
REQ-031 Assertion of wrrst mid-packet SHALL abandon the packet immediately, without completing the current beat.
REQ-032 After wrrst deasserts, arbitration SHALL restart from requester 0 on the first rising edge.

Verification
REQ-033 Reset, then req=4'b1010 held with last=1 on every beat, full=0 -> gnt sequence 0010, (idle), 1000, (idle), 0010; one ack per grant.
REQ-034 Requester 0 sends a 3-beat packet (last on beat 3) and requester 2 requests throughout -> wren high 3 cycles with ack[0]; gnt[2] only after IDLE cycle.
REQ-035 full=1 for 4 cycles in mid-packet -> wren=0 and ack=0 for those cycles, gnt unchanged; the packet resumes with no beat dropped or duplicated.
REQ-036 Requester 1 streams 16 beats with last=0, MAXBEAT=16 -> release after beat 16, ovf_err=1, ptr=2; ovf_err still 1 after later normal packets.
REQ-037 wrrst pulse during beat 2 of a packet -> gnt, busy, wren, ovf_err immediately 0; next grant goes to the lowest set req bit from index 0.
REQ-038 req[owner] drops for 2 cycles mid-packet while others request -> busy stays 1, gnt unchanged, wren=0 for those cycles; the packet completes normally.
